// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with iterative shift-add multiply and restoring divide.
// Optional macro SEQ_ALU_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR  = 4'd9,  OP_SRA  = 4'd10, OP_ROL  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12, OP_SLT = 4'd13, OP_MAXU = 4'd14, OP_PASS = 4'd15;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]     mp_q, mp_d;
  logic [SHW:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [3:0]           flags_q, flags_d;

  logic [SHW-1:0]       sh;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   rot;
  logic [2*WIDTH-1:0]   imm_res;
  logic                 imm_carry, imm_ovf, imm_dbz;
  logic [WIDTH:0]       div_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   fin_res;
  logic                 finish;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  // Single-cycle datapath, evaluated straight from the input operands at accept.
  always_comb begin
    sh        = b[SHW-1:0];
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    rot       = {a, a} << sh;
    imm_res   = '0;
    imm_carry = 1'b0;
    imm_ovf   = 1'b0;
    imm_dbz   = 1'b0;
    case (opcode)
      OP_ADD: begin
        imm_res[WIDTH:0] = sum;
        imm_carry        = sum[WIDTH];
        imm_ovf          = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        imm_res[WIDTH-1:0] = diff;
        imm_carry          = (a < b);
        imm_ovf            = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIV: begin
        imm_res = {a, {WIDTH{1'b1}}};
        imm_dbz = 1'b1;
      end
      OP_AND:  imm_res[WIDTH-1:0] = a & b;
      OP_OR:   imm_res[WIDTH-1:0] = a | b;
      OP_XOR:  imm_res[WIDTH-1:0] = a ^ b;
      OP_NOT:  imm_res[WIDTH-1:0] = ~a;
      OP_SHL:  imm_res[WIDTH-1:0] = a << sh;
      OP_SHR:  imm_res[WIDTH-1:0] = a >> sh;
      OP_SRA:  imm_res[WIDTH-1:0] = $signed(a) >>> sh;
      OP_ROL:  imm_res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
      OP_SLTU: imm_res[0] = (a < b);
      OP_SLT:  imm_res[0] = ($signed(a) < $signed(b));
      OP_MAXU: imm_res[WIDTH-1:0] = (a > b) ? a : b;
      OP_PASS: imm_res[WIDTH-1:0] = a;
      default: imm_res = '0;
    endcase
  end

  always_comb begin
    div_sh  = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, b_q});
    div_rem = div_sh[WIDTH-1:0] - b_q;
    fin_res = (op_q == OP_MUL) ? acc_q : {acc_q[WIDTH-1:0], mp_q};
`ifdef SEQ_ALU_EARLY_TERM_EN
    finish  = (op_q == OP_MUL) ? (mp_q == '0) : (cnt_q == CNT_LAST);
`else
    finish  = (cnt_q == CNT_LAST);
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = opcode;
          b_d   = b;
          acc_d = '0;
          mc_d  = {{WIDTH{1'b0}}, a};
          mp_d  = (opcode == OP_DIV) ? a : b;
          cnt_d = '0;
`ifdef SEQ_ALU_EARLY_TERM_EN
          if ((opcode == OP_MUL && b != '0) || (opcode == OP_DIV && b != '0)) begin
`else
          if (opcode == OP_MUL || (opcode == OP_DIV && b != '0)) begin
`endif
            state_d = S_BUSY;
          end else begin
            // Only reachable for MUL here when early termination skips a zero multiplier.
            state_d  = S_DONE;
            result_d = (opcode == OP_MUL) ? '0 : imm_res;
            flags_d  = (opcode == OP_MUL) ? 4'b0001
                     : {imm_dbz, imm_ovf, imm_carry, (imm_res == '0)};
          end
        end
      end
      S_BUSY: begin
        if (finish) begin
          state_d  = S_DONE;
          result_d = fin_res;
          flags_d  = {3'b000, (fin_res == '0)};
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q == OP_MUL) begin
            if (mp_q[0]) acc_d = acc_q + mc_q;
            mc_d = mc_q << 1;
            mp_d = mp_q >> 1;
          end else begin
            acc_d = {{WIDTH{1'b0}}, (div_ge ? div_rem : div_sh[WIDTH-1:0])};
            mp_d  = {mp_q[WIDTH-2:0], div_ge};
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=16).
module tb_seq_alu;
  localparam int W = 16;
`ifdef SEQ_ALU_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [3:0]     opcode = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic [3:0]     flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat);
    @(negedge clk);
    check_eq("in_ready_before_issue", in_ready, 1);
    opcode = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = i;
    end
  endtask

  task automatic pop;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq("in_ready_after_pop", in_ready, 1);
    check_eq("out_valid_after_pop", out_valid, 0);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic [2*W-1:0] exp_res,
                     input logic [3:0] exp_flags, input int exp_lat);
    int lat;
    issue(op, av, bv, lat);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_flags"}, flags, exp_flags);
    pop();
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] held;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    @(negedge clk) rst_n = 1'b1;

    run("add_carry", 4'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 4'b0010, 1);
    run("sub_ovf",   4'd1, 16'h8000, 16'h0001, 32'h0000_7FFF, 4'b0100, 1);
    run("sub_zero",  4'd1, 16'd5,    16'd5,    32'h0,         4'b0001, 1);
    run("sub_borrow",4'd1, 16'd3,    16'd5,    32'h0000_FFFE, 4'b0010, 1);
    run("mul",       4'd2, 16'h1234, 16'h00FF, 32'h0012_21CC, 4'b0000, EARLY ? 9 : 17);
    run("mul_b1",    4'd2, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 4'b0000, EARLY ? 2 : 17);
    run("mul_b0",    4'd2, 16'h1234, 16'h0000, 32'h0,         4'b0001, EARLY ? 1 : 17);
    run("mul_full",  4'd2, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0000, 17);
    run("div",       4'd3, 16'd100,  16'd7,    {16'd2, 16'd14}, 4'b0000, 17);
    run("div_big",   4'd3, 16'hFFFF, 16'h0010, 32'h000F_0FFF, 4'b0000, 17);
    run("div_dbz",   4'd3, 16'h00AB, 16'h0000, 32'h00AB_FFFF, 4'b1000, 1);
    run("xor",       4'd6, 16'hF0F0, 16'hFF00, 32'h0000_0FF0, 4'b0000, 1);
    run("not",       4'd7, 16'h00FF, 16'h0000, 32'h0000_FF00, 4'b0000, 1);
    run("shl",       4'd8, 16'h1001, 16'h0013, 32'h0000_8008, 4'b0000, 1);
    run("sra",       4'd10,16'h8000, 16'h0004, 32'h0000_F800, 4'b0000, 1);
    run("rol",       4'd11,16'h8001, 16'h0001, 32'h0000_0003, 4'b0000, 1);
    run("sltu",      4'd12,16'h0001, 16'hFFFF, 32'h0000_0001, 4'b0000, 1);
    run("maxu",      4'd14,16'h0003, 16'hFFFE, 32'h0000_FFFE, 4'b0000, 1);
    run("pass",      4'd15,16'h0000, 16'h1234, 32'h0,         4'b0001, 1);

    // Backpressure: result must hold while new requests are presented and ignored.
    issue(4'd0, 16'h0102, 16'h0304, lat);
    check_eq("bp_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      opcode = 4'd15; a = 16'hDEAD; b = 16'h0; in_valid = 1'b1;
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_result", result, 32'h0000_0406);
      check_eq("bp_flags", flags, 4'b0000);
    end
    @(negedge clk) in_valid = 1'b0;
    pop();
    run("after_bp", 4'd5, 16'h00F0, 16'h000F, 32'h0000_00FF, 4'b0000, 1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    opcode = 4'd2; a = 16'h1234; b = 16'h00FF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    held = result;
    repeat (3) @(posedge clk);
    #1 check_eq("midrst_still_idle", {out_valid, held}, {1'b0, 32'h0});
    @(negedge clk) rst_n = 1'b1;
    run("slt_after_rst", 4'd13, 16'hFFFF, 16'h0001, 32'h0000_0001, 4'b0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
